multi_pulse_counter: RTL and testbench



---
 rtl/multi_pulse_counter_pkg.sv | 29 ++
 rtl/pulse_toggle_sync.sv | 35 +++
 rtl/multi_pulse_counter.sv | 94 +++++++++
 tb/tb_multi_pulse_counter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_pulse_counter_pkg.sv
// Shared constants and helpers for the multi-channel pulse counter.
// Counter mode encodings, max-value helper and parameter range check.
package multi_pulse_counter_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  function automatic logic [31:0] cnt_max(input int w);
    logic [32:0] m;
    m = (33'd1 << w) - 33'd1;
    return m[31:0];
  endfunction

  function automatic bit cfg_ok(
    input int nch,
    input int w,
    input int ss,
    input int sat,
    input int thr
  );
    return (nch >= 1) && (nch <= 16) &&
           (w >= 2) && (w <= 32) &&
           (ss >= 2) && (ss <= 4) &&
           ((sat == MODE_WRAP) || (sat == MODE_SAT)) &&
           (thr >= 0) &&
           (33'(thr) <= {1'b0, cnt_max(w)});
  endfunction

endpackage

// File: rtl/pulse_toggle_sync.sv
// Pulse-clocked toggle flop, clk-domain synchroniser and edge detector.
// Emits a one-cycle ev for each rising edge seen on pulse.
module pulse_toggle_sync
  import multi_pulse_counter_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pulse,
  output logic ev
);

  logic                   tog;
  logic [SYNC_STAGES-1:0] s;
  logic                   h;

  always_ff @(posedge pulse or negedge rst_n) begin
    if (!rst_n) tog <= 1'b0;
    else        tog <= ~tog;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s <= '0;
      h <= 1'b0;
    end else begin
      s <= {s[SYNC_STAGES-2:0], tog};
      h <= s[SYNC_STAGES-1];
    end
  end

  assign ev = s[SYNC_STAGES-1] ^ h;

endmodule

// File: rtl/multi_pulse_counter.sv
// Multi-channel toggle-synchronised pulse counter with snapshot,
// sticky overflow and threshold flags.
module multi_pulse_counter
  import multi_pulse_counter_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int SAT_MODE    = 0,
  parameter int THRESH      = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       pulse,
  input  logic                    en,
  input  logic [NUM_CH-1:0]       clr,
  input  logic                    snap,
  output logic [NUM_CH*CNT_W-1:0] count,
  output logic [NUM_CH*CNT_W-1:0] snap_cnt,
  output logic                    snap_vld,
  output logic [NUM_CH-1:0]       ovf,
  output logic [NUM_CH-1:0]       thr_hit
);

  localparam logic [CNT_W-1:0] MAX = CNT_W'(cnt_max(CNT_W));
  localparam logic [CNT_W-1:0] THR = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  if (!cfg_ok(NUM_CH, CNT_W, SYNC_STAGES, SAT_MODE, THRESH))
  begin : g_bad_cfg
    $error("multi_pulse_counter: parameter out of range");
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) snap_vld <= 1'b0;
    else        snap_vld <= snap;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic             ev;
    logic             inc;
    logic             at_max;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] snap_q;
    logic             ovf_q;
    logic             hit_q;

    pulse_toggle_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .pulse(pulse[i]),
      .ev   (ev)
    );

    assign inc    = ev & en;
    assign at_max = (cnt_q == MAX);

    // clr beats snap beats counting; a snapped event opens the new window
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q  <= '0;
        snap_q <= '0;
        ovf_q  <= 1'b0;
        hit_q  <= 1'b0;
      end else begin
        if (snap) snap_q <= cnt_q;
        if (clr[i]) begin
          cnt_q <= '0;
          ovf_q <= 1'b0;
          hit_q <= 1'b0;
        end else if (snap) begin
          cnt_q <= inc ? ONE : '0;
          if (inc && (ONE == THR)) hit_q <= 1'b1;
        end else if (inc) begin
          if (at_max) begin
            ovf_q <= 1'b1;
            if (SAT_MODE == MODE_WRAP) cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + ONE;
            if ((cnt_q + ONE) == THR) hit_q <= 1'b1;
          end
        end
      end
    end

    assign count[i*CNT_W +: CNT_W]    = cnt_q;
    assign snap_cnt[i*CNT_W +: CNT_W] = snap_q;
    assign ovf[i]                     = ovf_q;
    assign thr_hit[i]                 = hit_q;
  end

endmodule

// File: tb/tb_multi_pulse_counter.sv
// Bench for multi_pulse_counter: wrap and saturate instances side by side,
// reference model plus snapshot scoreboard.
module tb_multi_pulse_counter;

  localparam int NCH  = 4;
  localparam int CW   = 4;
  localparam int SS   = 2;
  localparam int THR  = 10;
  localparam int LAT  = SS + 1;
  localparam int MAXV = (1 << CW) - 1;
  localparam int W    = NCH * CW;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic           en    = 1'b0;
  logic           snap  = 1'b0;
  logic [NCH-1:0] pulse = '0;
  logic [NCH-1:0] clr   = '0;

  logic [W-1:0]   count    [2];
  logic [W-1:0]   snap_cnt [2];
  logic           snap_vld [2];
  logic [NCH-1:0] ovf      [2];
  logic [NCH-1:0] thr_hit  [2];

  multi_pulse_counter #(
    .NUM_CH(NCH), .CNT_W(CW), .SYNC_STAGES(SS),
    .SAT_MODE(0), .THRESH(THR)
  ) dut_wrap (
    .clk(clk), .rst_n(rst_n), .pulse(pulse), .en(en),
    .clr(clr), .snap(snap), .count(count[0]),
    .snap_cnt(snap_cnt[0]), .snap_vld(snap_vld[0]),
    .ovf(ovf[0]), .thr_hit(thr_hit[0])
  );

  multi_pulse_counter #(
    .NUM_CH(NCH), .CNT_W(CW), .SYNC_STAGES(SS),
    .SAT_MODE(1), .THRESH(THR)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .pulse(pulse), .en(en),
    .clr(clr), .snap(snap), .count(count[1]),
    .snap_cnt(snap_cnt[1]), .snap_vld(snap_vld[1]),
    .ovf(ovf[1]), .thr_hit(thr_hit[1])
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: event landing times, counts as plain integers
  int  m_cnt [2][NCH];
  bit  m_ovf [2][NCH];
  bit  m_hit [2][NCH];
  bit  m_vld;
  bit  sched [NCH][64];
  int  cyc;
  logic [2*W-1:0] snap_q[$];

  function automatic logic [W-1:0] pack_cnt(input int d);
    logic [W-1:0] v;
    for (int i = 0; i < NCH; i++) v[i*CW +: CW] = CW'(m_cnt[d][i]);
    return v;
  endfunction

  function automatic logic [NCH-1:0] pack_ovf(input int d);
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = m_ovf[d][i];
    return v;
  endfunction

  function automatic logic [NCH-1:0] pack_hit(input int d);
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = m_hit[d][i];
    return v;
  endfunction

  always @(posedge clk) begin
    logic [2*W-1:0] shot;
    bit inc;
    int nxt;
    cyc++;
    if (rst_n) begin
      shot = {pack_cnt(1), pack_cnt(0)};
      for (int i = 0; i < NCH; i++) begin
        inc = sched[i][cyc % 64] && en;
        sched[i][cyc % 64] = 1'b0;
        for (int d = 0; d < 2; d++) begin
          if (clr[i]) begin
            m_cnt[d][i] = 0;
            m_ovf[d][i] = 1'b0;
            m_hit[d][i] = 1'b0;
          end else if (snap) begin
            m_cnt[d][i] = inc ? 1 : 0;
            if (inc && THR == 1) m_hit[d][i] = 1'b1;
          end else if (inc) begin
            nxt = m_cnt[d][i] + 1;
            if (nxt > MAXV) begin
              m_ovf[d][i] = 1'b1;
              m_cnt[d][i] = (d == 1) ? MAXV : nxt % (MAXV + 1);
            end else begin
              m_cnt[d][i] = nxt;
              if (nxt == THR) m_hit[d][i] = 1'b1;
            end
          end
        end
      end
      if (snap) snap_q.push_back(shot);
      m_vld = snap;
    end
  end

  always @(negedge rst_n) begin
    for (int i = 0; i < NCH; i++) begin
      for (int d = 0; d < 2; d++) begin
        m_cnt[d][i] = 0;
        m_ovf[d][i] = 1'b0;
        m_hit[d][i] = 1'b0;
      end
      for (int k = 0; k < 64; k++) sched[i][k] = 1'b0;
    end
    m_vld = 1'b0;
    snap_q.delete();
  end

  // Monitor: live state every cycle, snapshots popped on snap_vld
  always @(negedge clk) begin
    logic [2*W-1:0] e;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("count[%0d]", d), count[d], pack_cnt(d));
      chk($sformatf("ovf[%0d]", d), ovf[d], pack_ovf(d));
      chk($sformatf("thr_hit[%0d]", d), thr_hit[d], pack_hit(d));
      chk($sformatf("snap_vld[%0d]", d), snap_vld[d], m_vld);
    end
    if (snap_vld[0]) begin
      if (snap_q.size() == 0) begin
        chk("snap_queue_empty", 1, 0);
      end else begin
        e = snap_q.pop_front();
        chk("snap_cnt[0]", snap_cnt[0], e[W-1:0]);
        chk("snap_cnt[1]", snap_cnt[1], e[2*W-1:W]);
      end
    end
  end

  task automatic step(input logic [NCH-1:0] p,
                      input logic [NCH-1:0] c = '0,
                      input logic s = 1'b0);
    @(posedge clk);
    #2;
    for (int i = 0; i < NCH; i++)
      if (p[i] && !pulse[i] && rst_n) sched[i][(cyc + LAT) % 64] = 1'b1;
    pulse = p;
    clr   = c;
    snap  = s;
  endtask

  task automatic idle(input int n);
    repeat (n) step('0);
  endtask

  task automatic chk_all_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_count"}, count[d], 0);
      chk({tag, "_snap_cnt"}, snap_cnt[d], 0);
      chk({tag, "_snap_vld"}, snap_vld[d], 0);
      chk({tag, "_ovf"}, ovf[d], 0);
      chk({tag, "_thr"}, thr_hit[d], 0);
    end
  endtask

  initial begin
    logic [NCH-1:0] rp;
    en = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk_all_zero("reset");
    rst_n = 1'b1;

    // ch0: five spaced pulses
    repeat (5) begin step(4'b0001); idle(3); end
    idle(LAT);
    chk("s1_ch0", count[0][3:0], 5);
    chk("s1_others", count[0][W-1:4], 0);

    // ch1: 17 pulses, wrap vs saturate
    repeat (17) begin step(4'b0010); step('0); end
    idle(LAT);
    chk("s2_wrap_cnt", count[0][7:4], 1);
    chk("s2_sat_cnt", count[1][7:4], 15);
    chk("s2_wrap_ovf", ovf[0][1], 1);
    chk("s2_sat_ovf", ovf[1][1], 1);

    // ch2: threshold then clear
    step('0, 4'hF);
    repeat (12) begin step(4'b0100); step('0); end
    idle(LAT);
    chk("s3_cnt", count[0][11:8], 12);
    chk("s3_thr", thr_hit[0][2], 1);
    step('0, 4'b0100);
    step('0);
    chk("s3_clr_cnt", count[0][11:8], 0);
    chk("s3_clr_thr", thr_hit[0][2], 0);
    chk("s3_clr_ovf", ovf[0][2], 0);

    // ch3: snap coincident with event
    step('0, 4'hF);
    repeat (7) begin step(4'b1000); step('0); end
    idle(LAT);
    step(4'b1000);
    step('0);
    step('0, '0, 1'b1);
    step('0);
    chk("s4_vld", snap_vld[0], 1);
    chk("s4_snap", snap_cnt[0][15:12], 7);
    chk("s4_cnt", count[0][15:12], 1);
    step('0);
    chk("s4_vld_low", snap_vld[0], 0);

    // enable gating
    step('0, 4'hF);
    en = 1'b0;
    repeat (3) begin step(4'b0001); step('0); end
    idle(LAT + 1);
    en = 1'b1;
    repeat (2) begin step(4'b0001); step('0); end
    idle(LAT);
    chk("s5_cnt", count[0][3:0], 2);

    // reset between pulses on all channels
    step('0, 4'hF);
    repeat (2) begin step(4'hF); step('0); end
    idle(LAT);
    chk("s6_pre", count[0], 16'h2222);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("s6_rst");
    step(4'hF);
    step('0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step(4'hF);
    step('0);
    idle(LAT);
    chk("s6_post", count[0], 16'h1111);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NCH; i++) rp[i] = ($urandom_range(0, 3) == 0);
      step(rp,
           ($urandom_range(0, 39) == 0) ? NCH'($urandom) : '0,
           ($urandom_range(0, 19) == 0));
      en = ($urandom_range(0, 9) != 0);
      if (n == 700) rst_n = 1'b0;
      if (n == 703) rst_n = 1'b1;
    end
    en = 1'b1;
    idle(LAT + 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
